flit_sink: RTL and testbench
============================

Name: flit_sink

Overview:
- Receive-side endpoint for a router00 output port (data_to_x/y/local, wr_next_*_en, next_full_*).
- Accepts 40-bit flits through the same wr_en/full push handshake the router uses on its inputs, and buffers them in a small FIFO.
- Checks each flit's header code and payload sequence, and presents buffered flits to the local consumer through a pop interface.
- One instance per router output under test or per local node.

Parameters:
- WD, 40: flit width.
- HDR_W, 4: header field width, bits [WD-1:WD-HDR_W].
- DEPTH, 8: FIFO entries; must be a power of 2.
- AW, 3: log2(DEPTH).
- FULL_MARGIN, 2: free entries reserved for flits already in flight when full asserts.
- EXP_HDR, 4'b0010: expected header code for this port (HDR_LOCAL).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous reset, active-high (1 = reset).
- wr_en  in  1  flit valid from router (wr_next_*_en).
- wdata  in  WD  flit from router (data_to_*).
- full  out  1  back-pressure to router next_full_*.
- rd_en  in  1  consumer pop request.
- rdata  out  WD  popped flit.
- rd_valid  out  1  rdata valid.
- empty  out  1  FIFO empty.
- count  out  AW+1  current occupancy, 0..DEPTH.
- clr_err  in  1  synchronous clear of checker state.
- hdr_err  out  1  sticky header mismatch.
- seq_err  out  1  sticky sequence mismatch.
- flit_cnt  out  16  accepted flits, wraps modulo 2^16.
- drop_cnt  out  8  dropped flits, saturates at 255.

Behaviour:
- Reset values: all outputs 0 except empty=1. Pointers 0, checker disarmed. Reset asserted mid-transfer discards FIFO contents immediately.
- full = (count >= DEPTH-FULL_MARGIN), combinational from the count register. At DEPTH=8 it asserts at count 6.
- Push accepted when wr_en && (count < DEPTH || (rd_en && !empty)). A simultaneous pop at count==DEPTH frees the slot in the same cycle.
- wr_en with no slot available: flit dropped, drop_cnt += 1 (saturating), FIFO and checker unaffected.
- Pop happens when rd_en && !empty. rdata and rd_valid are registered, so latency is 1 cycle from rd_en to rd_valid=1. rd_en while empty is ignored and gives rd_valid=0 next cycle. rdata holds its last value when rd_valid=0.
- count next = count + push - pop. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Checker acts on accepted flits only:
  - hdr = wdata[WD-1:WD-HDR_W]. hdr != EXP_HDR sets hdr_err.
  - payload = wdata[WD-HDR_W-1:0].
  - Disarmed state: first accepted flit loads exp = payload+1 and arms the checker. No seq check on that flit.
  - Armed state: payload != exp sets seq_err. exp <= payload+1 always, which resyncs after an error.
  - Payload arithmetic is modulo 2^(WD-HDR_W); 36'hF_FFFF_FFFF followed by 0 is legal.
- Checker states: DISARMED -> ARMED on first accepted flit. ARMED -> DISARMED on clr_err.
- clr_err clears hdr_err, seq_err and flit_cnt, and disarms the checker. It does not clear FIFO contents or drop_cnt. When clr_err coincides with an accepted flit, that flit is checked as the first flit after the clear.
- flit_cnt increments on every accepted push.

Decomposition:
- Package noc_pkg holds:
  - WD=40, HDR_W=4.
  - Header codes HDR_X=4'b0100, HDR_Y=4'b1000, HDR_LOCAL=4'b0010.
  - Typedef flit_t = logic [WD-1:0].
- Sub-module sync_fifo (DEPTH, WD): storage, pointers, count, push/pop. flit_sink adds the full threshold, drop logic, checker and counters.

Test Plan:
- Reset, then 5 flits {4'b0010, 36'h0}..{4'b0010, 36'h4}, one per cycle, no pops -> count=5, full=0, flit_cnt=5, hdr_err=0, seq_err=0.
- Continuous flits, no pops -> full=1 once count=6. Router honours full after 2 in-flight flits -> count=8, drop_cnt=0. A third in-flight flit -> drop_cnt=1.
- count=8, wr_en and rd_en in the same cycle -> push accepted, count stays 8, next cycle rd_valid=1 with rdata = oldest flit.
- Payload sequence 0,1,3 -> seq_err=1 on the third flit. Then 4 -> no new error (resync). Then clr_err -> seq_err=0, next flit of any payload gives no error.
- Flit with header 4'b0100 -> hdr_err=1. Payload 36'hF_FFFF_FFFF followed by 36'h0 -> seq_err stays 0.
- rst_n pulsed while count=4 -> count=0, empty=1, flit_cnt=0, checker disarmed, rd_en next cycle gives rd_valid=0.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit geometry, header codes and checker state encoding
package noc_pkg;
  localparam int WD = 40;
  localparam int HDR_W = 4;
  localparam logic [HDR_W-1:0] HDR_X = 4'b0100;
  localparam logic [HDR_W-1:0] HDR_Y = 4'b1000;
  localparam logic [HDR_W-1:0] HDR_LOCAL = 4'b0010;
  typedef logic [WD-1:0] flit_t;
  typedef enum logic {DISARMED, ARMED} chk_state_t;
  function automatic flit_t mk_flit(logic [HDR_W-1:0] h, logic [WD-HDR_W-1:0] p);
    return {h, p};
  endfunction
endpackage

// File: rtl/flit_sink_if.sv
// flit_sink_if: router push channel plus consumer pop channel of a flit sink
interface flit_sink_if
  import noc_pkg::*;
#(parameter int AW = 3);
  logic wr_en;
  flit_t wdata;
  logic full;
  logic rd_en;
  flit_t rdata;
  logic rd_valid;
  logic empty;
  logic [AW:0] count;
  modport master (output wr_en, wdata, rd_en, input full, rdata, rd_valid, empty, count);
  modport slave (input wr_en, wdata, rd_en, output full, rdata, rd_valid, empty, count);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 flit FIFO with registered read port and occupancy count
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WD = 40,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WD-1:0] wdata,
  output logic [WD-1:0] rdata,
  output logic rd_valid,
  output logic [AW:0] count,
  output logic empty
);
  logic [WD-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  // at count==DEPTH a same-cycle push overwrites the slot being read, which still yields the old entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rd_valid <= 1'b0;
      rdata <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      rd_valid <= pop;
      if (pop) rdata <= mem[rptr];
    end
  assign empty = count == '0;
endmodule

// File: rtl/flit_sink.sv
// flit_sink: router output endpoint buffering flits and checking header code and payload sequence
module flit_sink
  import noc_pkg::*;
#(
  parameter int WD = noc_pkg::WD,
  parameter int HDR_W = noc_pkg::HDR_W,
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int FULL_MARGIN = 2,
  parameter logic [HDR_W-1:0] EXP_HDR = HDR_LOCAL
) (
  input  logic clk,
  input  logic rst_n,
  flit_sink_if.slave bus,
  input  logic clr_err,
  output logic hdr_err,
  output logic seq_err,
  output logic [15:0] flit_cnt,
  output logic [7:0] drop_cnt
);
  localparam int PW = WD - HDR_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] FULL_TH = (AW+1)'(DEPTH - FULL_MARGIN);
  logic push, pop;
  logic [AW:0] cnt;
  logic [HDR_W-1:0] hdr;
  logic [PW-1:0] payload, exp_pl, exp_nx;
  chk_state_t state, state_nx;
  logic hdr_nx, seq_nx, seq_hit;
  logic [15:0] fcnt_nx;
  logic [7:0] dcnt_nx;
  assign pop = bus.rd_en && !bus.empty;
  assign push = bus.wr_en && (cnt < DEPTH_C || pop);
  assign bus.count = cnt;
  assign bus.full = cnt >= FULL_TH;
  assign hdr = bus.wdata[WD-1 -: HDR_W];
  assign payload = bus.wdata[PW-1:0];
  sync_fifo #(.DEPTH(DEPTH), .WD(WD), .AW(AW)) u_fifo (
    .clk(clk),
    .rst(rst_n),
    .push(push),
    .pop(pop),
    .wdata(bus.wdata),
    .rdata(bus.rdata),
    .rd_valid(bus.rd_valid),
    .count(cnt),
    .empty(bus.empty)
  );
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state <= DISARMED;
      exp_pl <= '0;
      hdr_err <= 1'b0;
      seq_err <= 1'b0;
      flit_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      exp_pl <= exp_nx;
      hdr_err <= hdr_nx;
      seq_err <= seq_nx;
      flit_cnt <= fcnt_nx;
      drop_cnt <= dcnt_nx;
    end
  // a flit arriving with clr_err is treated as the first flit after the clear
  always_comb begin
    state_nx = push ? ARMED : clr_err ? DISARMED : state;
    seq_hit = push && state == ARMED && !clr_err && payload != exp_pl;
    hdr_nx = (hdr_err && !clr_err) || (push && hdr != EXP_HDR);
    seq_nx = (seq_err && !clr_err) || seq_hit;
    exp_nx = push ? payload + PW'(1) : exp_pl;
    fcnt_nx = (clr_err ? 16'd0 : flit_cnt) + 16'(push);
    dcnt_nx = drop_cnt + 8'(bus.wr_en && !push && drop_cnt != 8'hFF);
  end
endmodule

// File: tb/tb_flit_sink.sv
// tb_flit_sink: queue-model scoreboard bench for flit_sink with directed and random traffic
module tb_flit_sink;
  import noc_pkg::*;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int PW = WD - HDR_W;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_err = 1'b0;
  logic hdr_err, seq_err;
  logic [15:0] flit_cnt;
  logic [7:0] drop_cnt;
  int checks = 0;
  int errors = 0;
  flit_t m_q[$];
  flit_t exp_q[$];
  flit_t m_last = '0;
  int m_fc = 0;
  int m_dc = 0;
  bit m_hdr = 0;
  bit m_seq = 0;
  bit m_armed = 0;
  logic [PW-1:0] m_exp = '0;

  flit_sink_if #(.AW(AW)) bus ();

  flit_sink dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .clr_err(clr_err),
    .hdr_err(hdr_err),
    .seq_err(seq_err),
    .flit_cnt(flit_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_step(input bit wr, input flit_t d, input bit rd, input bit clr);
    bit popped, acc;
    popped = rd && m_q.size() > 0;
    acc = wr && (m_q.size() < DEPTH || popped);
    if (clr) begin
      m_hdr = 0;
      m_seq = 0;
      m_fc = 0;
      m_armed = 0;
    end
    if (popped) exp_q.push_back(m_q.pop_front());
    if (acc) begin
      m_q.push_back(d);
      m_fc = (m_fc + 1) % 65536;
      if (d[WD-1 -: HDR_W] != HDR_LOCAL) m_hdr = 1;
      if (m_armed && d[PW-1:0] != m_exp) m_seq = 1;
      m_exp = d[PW-1:0] + 1;
      m_armed = 1;
    end else if (wr && m_dc < 255) m_dc++;
  endtask

  task automatic drive(input bit wr, input flit_t d, input bit rd, input bit clr);
    @(negedge clk);
    bus.wr_en = wr;
    bus.wdata = d;
    bus.rd_en = rd;
    clr_err = clr;
    model_step(wr, d, rd, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    clr_err = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_last = '0;
    m_fc = 0;
    m_dc = 0;
    m_hdr = 0;
    m_seq = 0;
    m_armed = 0;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    flit_t f;
    #1;
    if (bus.rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid got 1 want 0 at %0t", $time);
      end else begin
        f = exp_q.pop_front();
        chk("rdata", bus.rdata, f);
        m_last = f;
      end
    end else begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        f = exp_q.pop_front();
        $display("FAIL rd_valid got 0 want 1 (flit %0h) at %0t", f, $time);
        m_last = f;
      end else chk("rdata_hold", bus.rdata, m_last);
    end
    chk("count", bus.count, m_q.size());
    chk("full", bus.full, m_q.size() >= DEPTH - 2);
    chk("empty", bus.empty, m_q.size() == 0);
    chk("flit_cnt", flit_cnt, m_fc);
    chk("drop_cnt", drop_cnt, m_dc);
    chk("hdr_err", hdr_err, m_hdr);
    chk("seq_err", seq_err, m_seq);
  end

  initial begin
    bit wr, rd, clr;
    logic [HDR_W-1:0] h;
    logic [PW-1:0] pl, seq_pl;
    bus.wr_en = 1'b0;
    bus.wdata = '0;
    bus.rd_en = 1'b0;
    do_reset();
    settle();
    chk("reset_empty", bus.empty, 1);
    chk("reset_count", bus.count, 0);
    for (int i = 0; i < 5; i++) drive(1, mk_flit(HDR_LOCAL, PW'(i)), 0, 0);
    settle();
    chk("five_count", bus.count, 5);
    chk("five_full", bus.full, 0);
    chk("five_flit_cnt", flit_cnt, 5);
    chk("five_errs", {hdr_err, seq_err}, 0);
    drive(1, mk_flit(HDR_LOCAL, 36'd5), 0, 0);
    settle();
    chk("full_at_6", bus.full, 1);
    drive(1, mk_flit(HDR_LOCAL, 36'd6), 0, 0);
    drive(1, mk_flit(HDR_LOCAL, 36'd7), 0, 0);
    settle();
    chk("inflight_count", bus.count, 8);
    chk("inflight_drop", drop_cnt, 0);
    drive(1, mk_flit(HDR_LOCAL, 36'd8), 0, 0);
    settle();
    chk("third_drop", drop_cnt, 1);
    drive(1, mk_flit(HDR_LOCAL, 36'd8), 1, 0);
    settle();
    chk("full_pushpop_count", bus.count, 8);
    chk("full_pushpop_valid", bus.rd_valid, 1);
    chk("full_pushpop_rdata", bus.rdata, mk_flit(HDR_LOCAL, 36'd0));
    repeat (8) drive(0, '0, 1, 0);
    drive(1, mk_flit(HDR_LOCAL, 36'd0), 1, 1);
    drive(1, mk_flit(HDR_LOCAL, 36'd1), 1, 0);
    drive(1, mk_flit(HDR_LOCAL, 36'd3), 1, 0);
    settle();
    chk("seq_skip", seq_err, 1);
    drive(1, mk_flit(HDR_LOCAL, 36'd4), 1, 0);
    drive(0, '0, 1, 1);
    settle();
    chk("clr_seq", seq_err, 0);
    chk("clr_flit_cnt", flit_cnt, 0);
    drive(1, mk_flit(HDR_LOCAL, 36'h123), 1, 0);
    settle();
    chk("after_clr_seq", seq_err, 0);
    drive(1, mk_flit(HDR_X, 36'h124), 1, 0);
    settle();
    chk("hdr_x", hdr_err, 1);
    drive(0, '0, 1, 1);
    drive(1, mk_flit(HDR_LOCAL, 36'hF_FFFF_FFFF), 1, 0);
    drive(1, mk_flit(HDR_LOCAL, 36'h0), 1, 0);
    settle();
    chk("wrap_seq", seq_err, 0);
    repeat (4) drive(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, mk_flit(HDR_LOCAL, PW'(10 + i)), 0, 0);
    settle();
    chk("pre_rst_count", bus.count, 4);
    do_reset();
    settle();
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_flit_cnt", flit_cnt, 0);
    drive(0, '0, 1, 0);
    settle();
    chk("rst_pop_valid", bus.rd_valid, 0);
    drive(1, mk_flit(HDR_LOCAL, 36'd99), 0, 0);
    settle();
    chk("rst_disarmed", seq_err, 0);
    seq_pl = 36'd100;
    for (int i = 0; i < 1500; i++) begin
      if (i == 800) do_reset();
      if (i == 600) seq_pl = 36'hF_FFFF_FFF0;
      wr = $urandom_range(0, 9) < 7;
      if (bus.full && $urandom_range(0, 9) != 0) wr = 0;
      h = ($urandom_range(0, 29) == 0) ? HDR_Y : HDR_LOCAL;
      pl = ($urandom_range(0, 29) == 0) ? PW'({$urandom(), $urandom()}) : seq_pl;
      rd = $urandom_range(0, 1) == 1;
      clr = $urandom_range(0, 49) == 0;
      drive(wr, mk_flit(h, pl), rd, clr);
      if (wr) seq_pl = pl + 1;
    end
    repeat (10) drive(0, '0, 1, 0);
    settle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
